// File: rtl/key_debounce_multi_pkg.sv
// ----------------------------------------------------------------------------
// key_debounce_multi_pkg
//   Shared definitions for the multi-channel key conditioner.
//   - KEY_PRESSED / KEY_RELEASED : polarity-normalised key levels
//   - clog2()                    : width helper for the tick and hold counters
//   No ports; imported by key_chan and key_debounce_multi.
// ----------------------------------------------------------------------------
package key_debounce_multi_pkg;

  localparam logic KEY_PRESSED  = 1'b1;
  localparam logic KEY_RELEASED = 1'b0;

  // Number of bits needed to hold the values 0..v-1, never less than 1 so
  // that a counter declared with this width is always legal.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/key_debounce_multi_chan.sv
// ----------------------------------------------------------------------------
// key_chan
//   One key channel: 2-FF synchroniser, DEPTH-sample stability filter,
//   debounced level, press/release pulses and a one-shot long-press pulse.
//   Ports:
//     clk           in  system clock
//     rst_n         in  asynchronous reset, active-low
//     tick          in  shared one-clk sample strobe
//     raw           in  asynchronous raw key pin
//     level         out debounced state, 1 = pressed
//     press         out 1-clk pulse on released->pressed
//     release_pulse out 1-clk pulse on pressed->released
//     long          out 1-clk pulse once per press after LONG_TICKS held ticks
// ----------------------------------------------------------------------------
module key_chan
  import key_debounce_multi_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int LONG_TICKS = 200,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long
);

  localparam logic            POL      = (ACTIVE_LOW != 0);
  localparam int              HW       = clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(LONG_TICKS);

  logic             sync_a;
  logic             sync_b;
  logic [DEPTH-1:0] sh;
  logic [DEPTH-1:0] sh_next;
  logic             rise;
  logic             fall;
  logic [HW-1:0]    hold;

  // The filter decision is made on the shift register value as it will be
  // after this tick, so the level changes on the same tick that completes
  // the run of DEPTH equal samples.
  always_comb begin
    sh_next = sh;
    rise    = 1'b0;
    fall    = 1'b0;
    if (tick) begin
      sh_next = {sh[DEPTH-2:0], sync_b};
      rise    = (&sh_next) && (level == KEY_RELEASED);
      fall    = (~|sh_next) && (level == KEY_PRESSED);
    end
  end

  // Synchroniser and filter: the raw pin is normalised to "1 = pressed"
  // before the first flop so everything downstream is polarity-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= KEY_RELEASED;
      sync_b <= KEY_RELEASED;
      sh     <= '0;
    end else begin
      sync_a <= raw ^ POL;
      sync_b <= sync_a;
      sh     <= sh_next;
    end
  end

  // Level, pulses and hold counter. The hold counter is also cleared on the
  // release tick itself, which keeps long and release from ever coinciding.
  // The press tick does not count because level is still 0 on that tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level         <= KEY_RELEASED;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long          <= 1'b0;
      hold          <= '0;
    end else begin
      press         <= rise;
      release_pulse <= fall;
      long          <= 1'b0;
      if (rise) begin
        level <= KEY_PRESSED;
      end else if (fall) begin
        level <= KEY_RELEASED;
      end
      if ((level == KEY_RELEASED) || fall) begin
        hold <= '0;
      end else if (tick && (hold != HOLD_MAX)) begin
        hold <= hold + 1'b1;
        long <= (hold == (HOLD_MAX - 1'b1));
      end
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// ----------------------------------------------------------------------------
// key_debounce_multi
//   N-channel push-button conditioner: one shared sample tick generator and
//   N_KEYS independent key_chan instances.
//   Ports:
//     clk          in  system clock
//     rst_n        in  asynchronous reset, active-low
//     key_raw      in  raw key pins, bit i = channel i
//     key_level    out debounced state, 1 = pressed
//     key_press    out 1-clk pulse on debounced released->pressed
//     key_release  out 1-clk pulse on debounced pressed->released
//     key_long     out 1-clk pulse once per press after LONG_TICKS held ticks
// ----------------------------------------------------------------------------
module key_debounce_multi
  import key_debounce_multi_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int CLK_DIV    = 500000,
  parameter int DEPTH      = 8,
  parameter int LONG_TICKS = 200,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int            CW       = clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  // Free-running divider; tick is registered so it is high for exactly the
  // one clk that follows the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == CNT_LAST);
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_chan #(
      .DEPTH      (DEPTH),
      .LONG_TICKS (LONG_TICKS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .raw           (key_raw[i]),
      .level         (key_level[i]),
      .press         (key_press[i]),
      .release_pulse (key_release[i]),
      .long          (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// ----------------------------------------------------------------------------
// tb_key_debounce_multi
//   Scoreboard bench for key_debounce_multi with N_KEYS=2, CLK_DIV=4, DEPTH=4,
//   LONG_TICKS=3, ACTIVE_LOW=1. Each scenario task pushes the pulses it
//   expects (keyed by clock-edge number since reset) and a negedge monitor
//   pops and compares them; any pulse not on the scoreboard is an error.
// ----------------------------------------------------------------------------
module tb_key_debounce_multi;

  localparam int N_KEYS     = 2;
  localparam int CLK_DIV    = 4;
  localparam int DEPTH      = 4;
  localparam int LONG_TICKS = 3;
  localparam int ACTIVE_LOW = 1;

  typedef struct {
    int         cyc;
    logic [5:0] ev;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N_KEYS-1:0] key_raw = 2'b11;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  key_debounce_multi #(
    .N_KEYS     (N_KEYS),
    .CLK_DIV    (CLK_DIV),
    .DEPTH      (DEPTH),
    .LONG_TICKS (LONG_TICKS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; edge numbers are the time base for
  // every expected pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Sample strobes take effect on edges CLK_DIV+1, 2*CLK_DIV+1, ...
  function automatic int next_tick(input int c);
    int first;
    first = CLK_DIV + 1;
    if (c <= first) return first;
    return c + ((CLK_DIV - ((c - first) % CLK_DIV)) % CLK_DIV);
  endfunction

  task automatic push_expect(input int c, input logic [1:0] p,
                             input logic [1:0] r, input logic [1:0] l);
    exp_t item;
    item.cyc = c;
    item.ev  = {l, r, p};
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc == c) begin
        sb[i].ev = sb[i].ev | item.ev;
        return;
      end
      if (sb[i].cyc > c) begin
        sb.insert(i, item);
        return;
      end
    end
    sb.push_back(item);
  endtask

  // Monitor: compare pulses against the scoreboard every clock.
  always @(negedge clk) begin
    logic [5:0] obs;
    if (rst_n && mon_en) begin
      obs = {key_long, key_release, key_press};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL missed_event@%0d: got nothing at %0d, want %b", sb[0].cyc, cyc, sb[0].ev);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        n_cmp++;
        if (obs !== sb[0].ev) begin
          n_bad++;
          $display("[TB] FAIL event@%0d: got lrp=%b want %b", cyc, obs, sb[0].ev);
        end
        void'(sb.pop_front());
      end else if (obs !== 6'b0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_pulse@%0d: got lrp=%b want 000000", cyc, obs);
      end
    end
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    key_raw = 2'b11;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({key_level, key_press, key_release, key_long} !== 8'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got %b want 00000000", {key_level, key_press, key_release, key_long});
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL idle_level: got %b want 00", key_level);
    end
  endtask

  task automatic test_press();
    int e;
    int tp;
    @(negedge clk);
    key_raw[0] = 1'b0;
    e  = next_tick(cyc + 3);
    tp = e + (DEPTH - 1) * CLK_DIV;
    push_expect(tp, 2'b01, 2'b00, 2'b00);
    push_expect(tp + LONG_TICKS * CLK_DIV, 2'b00, 2'b00, 2'b01);
    while (cyc < tp - 1) @(negedge clk);
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL level_before_press: got %b want 00", key_level);
    end
    @(negedge clk);
    n_cmp++;
    if (key_level !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL level_at_press: got %b want 01", key_level);
    end
  endtask

  task automatic test_long();
    int e;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL long_drain: got %0d pending want 0", sb.size());
      sb.delete();
    end
    repeat (6 * CLK_DIV) @(negedge clk);
    n_cmp++;
    if (key_level !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL level_held: got %b want 01", key_level);
    end
    key_raw[0] = 1'b1;
    e = next_tick(cyc + 3);
    push_expect(e + (DEPTH - 1) * CLK_DIV, 2'b00, 2'b01, 2'b00);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL release_drain: got %0d pending want 0", sb.size());
      sb.delete();
    end
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL level_after_release: got %b want 00", key_level);
    end
  endtask

  // Three pressed samples, one released sample, then pressed again: only
  // the later run of four pressed samples may produce a press.
  task automatic test_bounce();
    int t0;
    int e;
    @(negedge clk);
    while (next_tick(cyc + 3) != cyc + 3) @(negedge clk);
    t0 = cyc + 3;
    key_raw[0] = 1'b0;
    push_expect(t0 + 16 + (DEPTH - 1) * CLK_DIV, 2'b01, 2'b00, 2'b00);
    push_expect(t0 + 16 + (DEPTH - 1 + LONG_TICKS) * CLK_DIV, 2'b00, 2'b00, 2'b01);
    while (cyc < t0 + 9) @(negedge clk);
    key_raw[0] = 1'b1;
    while (cyc < t0 + 13) @(negedge clk);
    key_raw[0] = 1'b0;
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL bounce_no_press: got %b want 00", key_level);
    end
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL bounce_drain: got %0d pending want 0", sb.size());
      sb.delete();
    end
    key_raw[0] = 1'b1;
    e = next_tick(cyc + 3);
    push_expect(e + (DEPTH - 1) * CLK_DIV, 2'b00, 2'b01, 2'b00);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL bounce_release_level: got %b want 00", key_level);
    end
  endtask

  // Both channels pressed together. Ch1 is let go on the tick after the
  // press; with a 4-sample filter and a 3-tick hold, the hold counter still
  // saturates one tick before the release is recognised.
  task automatic test_back_to_back();
    int e;
    int tp;
    @(negedge clk);
    key_raw = 2'b00;
    e  = next_tick(cyc + 3);
    tp = e + (DEPTH - 1) * CLK_DIV;
    push_expect(tp, 2'b11, 2'b00, 2'b00);
    push_expect(tp + LONG_TICKS * CLK_DIV, 2'b00, 2'b00, 2'b11);
    while (cyc < tp) @(negedge clk);
    n_cmp++;
    if (key_level !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL dual_level: got %b want 11", key_level);
    end
    key_raw[1] = 1'b1;
    e = next_tick(cyc + 3);
    push_expect(e + (DEPTH - 1) * CLK_DIV, 2'b00, 2'b10, 2'b00);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL dual_drain: got %0d pending want 0", sb.size());
      sb.delete();
    end
    repeat (3 * CLK_DIV) @(negedge clk);
    n_cmp++;
    if (key_level !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL dual_after_release: got %b want 01", key_level);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    int tp;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({key_level, key_press, key_release, key_long} !== 8'b0) begin
      n_bad++;
      $display("[TB] FAIL async_reset: got %b want 00000000", {key_level, key_press, key_release, key_long});
    end
    @(negedge clk);
    rst_n = 1'b1;
    e  = next_tick(cyc + 3);
    tp = e + (DEPTH - 1) * CLK_DIV;
    push_expect(tp, 2'b01, 2'b00, 2'b00);
    push_expect(tp + LONG_TICKS * CLK_DIV, 2'b00, 2'b00, 2'b01);
    while (cyc < tp - 1) @(negedge clk);
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL repress_early: got %b want 00", key_level);
    end
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL repress_drain: got %0d pending want 0", sb.size());
      sb.delete();
    end
    repeat (2 * CLK_DIV) @(negedge clk);
    n_cmp++;
    if (key_level !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL repress_level: got %b want 01", key_level);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_long();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
